id_issue_stage: RTL
===================

ID_ISSUE_STAGE -- requirements
Module: id_issue_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/bypass data width.
REQ-002 Parameter REG_AW, default 5, register address width.
REQ-003 Parameter NUM_BP, default 3, bypass channel count; index 0 = youngest (EXE), NUM_BP-1 = oldest (WB).
REQ-004 Parameter PAYLOAD_W, default 96, opaque decoded-control payload width.
REQ-005 Ports clk input 1 (clock) and reset input 1 (reset); one clock, reset asynchronous and active-high.
REQ-006 in_valid input 1, upstream instruction valid; in_allow output 1, stage can accept.
REQ-007 in_payload input PAYLOAD_W; in_raddr1/in_raddr2 input REG_AW each; in_use1/in_use2 input 1 each, operand reads a register.
REQ-008 rf_raddr1/rf_raddr2 output REG_AW, held instruction's read addresses; rf_rdata1/rf_rdata2 input DATA_W, combinational register-file read data.
REQ-009 bp_valid, bp_wen, bp_data_ok input NUM_BP each; bp_waddr input NUM_BP*REG_AW; bp_wdata input NUM_BP*DATA_W; channel i occupies slice i.
REQ-010 flush input 1, discard held instruction (branch mispredict).
REQ-011 out_valid output 1; out_allow input 1 (downstream allow-in); out_payload output PAYLOAD_W; out_src1/out_src2 output DATA_W.
REQ-012 stall_cnt output 32 (present only per REQ-030).

Function
REQ-013 Stage SHALL hold one instruction: held_valid, payload, raddr1/2, use1/2 registers.
REQ-014 ready_go = src1_ok AND src2_ok; in_allow = NOT held_valid OR (ready_go AND out_allow); out_valid = held_valid AND ready_go AND NOT flush.
REQ-015 Channel i matches operand k when bp_valid[i] AND bp_wen[i] AND bp_waddr[i]==raddr_k AND raddr_k!=0 AND use_k.
REQ-016 Lowest-index matching channel wins; older matches ignored.
REQ-017 Operand k: winner with bp_data_ok=1 -> bp_wdata of winner, ok; winner with bp_data_ok=0 -> value 0, not ok (stall); no match -> rf_rdata_k, ok; use_k=0 -> ok, value unchanged from payload-selected source (0 driven).
REQ-018 Register 0 SHALL never match and SHALL read as rf_rdata (expected 0).
REQ-019 Operand values combinational each cycle; while held and stalled, bypass re-evaluated every cycle, no latching.
REQ-020 Load: on in_allow AND in_valid AND NOT flush, capture inputs next edge, held_valid<=1; on in_allow AND NOT in_valid, held_valid<=0.
REQ-021 flush SHALL dominate: next edge held_valid<=0, no capture, regardless of in_valid/in_allow.
REQ-022 Held instruction unchanged while held_valid AND NOT (ready_go AND out_allow).
REQ-023 Zero-bubble throughput: issue and new capture on same edge when ready_go AND out_allow AND in_valid.
REQ-024 Latency: instruction with no hazard presents out_valid the cycle after capture.
REQ-025 Payload passes unmodified; out_payload = held payload.

Reset
REQ-026 Asynchronous assertion of reset SHALL immediately clear held_valid and zero payload, raddr, use registers.
REQ-027 During reset: out_valid=0, in_allow=1, out_src1/out_src2=rf_rdata-derived or 0 with use=0 -> 0, stall_cnt=0.
REQ-028 Reset mid-stall SHALL drop the held instruction; no issue after deassertion without new capture.
REQ-029 Deassertion synchronous-safe: first capture possible on first edge after deassertion.

Configuration
REQ-030 Macro ID_STALL_CNT_EN defined: stall_cnt 32-bit counter increments each cycle held_valid AND NOT ready_go AND NOT flush, saturates at 0xFFFFFFFF, reset to 0.
REQ-031 Macro undefined: stall_cnt port and counter absent; all other behaviour identical.

Verification
REQ-032 Independent stream: raddr1=3 rf_rdata1=0x11, no bp match -> out_src1=0x11 one cycle after capture, back-to-back issue every cycle.
REQ-033 Priority: ch0 and ch2 both write r5 (data 0xAAAA, 0xCCCC, data_ok=1), raddr2=5 -> out_src2=0xAAAA.
REQ-034 Load-use: ch0 writes r7 data_ok=0 for 2 cycles then data_ok=1 value 0x1234 -> out_valid low 2 cycles, then out_src1=0x1234; stall_cnt=2 with ID_STALL_CNT_EN.
REQ-035 r0 hazard: ch0 wen=1 waddr=0 data_ok=0, raddr1=0 -> no stall, out_src1=rf_rdata1=0.
REQ-036 flush while stalled and in_valid=1 -> next cycle held_valid=0, out_valid=0, new instruction not captured.
REQ-037 Backpressure: out_allow=0 5 cycles with ready_go=1 -> out_valid=1, payload stable, in_allow=0; no stall_cnt increment.

Source files
------------

// File: rtl/id_issue_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_issue_stage_if : upstream, downstream, register-file and bypass bundle  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface id_issue_stage_if #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int NUM_BP    = 3,
    parameter int PAYLOAD_W = 96
) ();
    logic                     in_valid;
    logic                     in_allow;
    logic [PAYLOAD_W-1:0]     in_payload;
    logic [REG_AW-1:0]        in_raddr1;
    logic [REG_AW-1:0]        in_raddr2;
    logic                     in_use1;
    logic                     in_use2;

    logic [REG_AW-1:0]        rf_raddr1;
    logic [REG_AW-1:0]        rf_raddr2;
    logic [DATA_W-1:0]        rf_rdata1;
    logic [DATA_W-1:0]        rf_rdata2;

    logic [NUM_BP-1:0]        bp_valid;
    logic [NUM_BP-1:0]        bp_wen;
    logic [NUM_BP-1:0]        bp_data_ok;
    logic [NUM_BP*REG_AW-1:0] bp_waddr;
    logic [NUM_BP*DATA_W-1:0] bp_wdata;

    logic                     flush;

    logic                     out_valid;
    logic                     out_allow;
    logic [PAYLOAD_W-1:0]     out_payload;
    logic [DATA_W-1:0]        out_src1;
    logic [DATA_W-1:0]        out_src2;

    modport slave (
        input  in_valid, in_payload, in_raddr1, in_raddr2, in_use1, in_use2,
        input  rf_rdata1, rf_rdata2,
        input  bp_valid, bp_wen, bp_data_ok, bp_waddr, bp_wdata,
        input  flush, out_allow,
        output in_allow, rf_raddr1, rf_raddr2,
        output out_valid, out_payload, out_src1, out_src2
    );

    modport master (
        output in_valid, in_payload, in_raddr1, in_raddr2, in_use1, in_use2,
        output rf_rdata1, rf_rdata2,
        output bp_valid, bp_wen, bp_data_ok, bp_waddr, bp_wdata,
        output flush, out_allow,
        input  in_allow, rf_raddr1, rf_raddr2,
        input  out_valid, out_payload, out_src1, out_src2
    );
endinterface
`default_nettype wire

// File: rtl/id_issue_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_issue_stage : one-entry decode/issue slot with priority operand bypass  |
// | Optional stall counter port under macro ID_STALL_CNT_EN.  Revision 1.0     |
// +----------------------------------------------------------------------------+
module id_issue_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int NUM_BP    = 3,
    parameter int PAYLOAD_W = 96
) (
    input  logic                  clk,
    input  logic                  reset,
    id_issue_stage_if.slave       bus
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);
    logic                        r_held_valid;
    logic [PAYLOAD_W-1:0]        r_payload;
    logic [1:0][REG_AW-1:0]      r_raddr;
    logic [1:0]                  r_use;

    logic [1:0][DATA_W-1:0]      w_rf;
    logic [1:0][DATA_W-1:0]      w_src;
    logic [1:0]                  w_ok;
    logic                        w_ready;

    assign w_rf = {bus.rf_rdata2, bus.rf_rdata1};

    // Scan oldest to youngest so the lowest-index matching channel is the last writer.
    for (genvar k = 0; k < 2; k++) begin : g_operand
        logic              w_hit;
        logic              w_hit_ok;
        logic [DATA_W-1:0] w_hit_data;

        always_comb begin
            w_hit      = 1'b0;
            w_hit_ok   = 1'b0;
            w_hit_data = '0;
            for (int i = NUM_BP - 1; i >= 0; i--) begin
                if (bus.bp_valid[i] && bus.bp_wen[i] &&
                    (bus.bp_waddr[i*REG_AW +: REG_AW] == r_raddr[k]) &&
                    (r_raddr[k] != '0)) begin
                    w_hit      = 1'b1;
                    w_hit_ok   = bus.bp_data_ok[i];
                    w_hit_data = bus.bp_wdata[i*DATA_W +: DATA_W];
                end
            end
        end

        assign w_ok[k]  = !r_use[k] || !w_hit || w_hit_ok;
        assign w_src[k] = !r_use[k] ? '0 :
                          !w_hit    ? w_rf[k] :
                          w_hit_ok  ? w_hit_data : '0;
    end

    assign w_ready         = &w_ok;
    assign bus.in_allow    = !r_held_valid || (w_ready && bus.out_allow);
    assign bus.out_valid   = r_held_valid && w_ready && !bus.flush;
    assign bus.out_payload = r_payload;
    assign bus.out_src1    = w_src[0];
    assign bus.out_src2    = w_src[1];
    assign bus.rf_raddr1   = r_raddr[0];
    assign bus.rf_raddr2   = r_raddr[1];

    // Flush wins over any capture, even when the slot would otherwise accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held_valid <= 1'b0;
            r_payload    <= '0;
            r_raddr      <= '0;
            r_use        <= '0;
        end else if (bus.flush) begin
            r_held_valid <= 1'b0;
        end else if (bus.in_allow) begin
            r_held_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_payload <= bus.in_payload;
                r_raddr   <= {bus.in_raddr2, bus.in_raddr1};
                r_use     <= {bus.in_use2, bus.in_use1};
            end
        end
    end

`ifdef ID_STALL_CNT_EN
    localparam logic [31:0] c_STALL_MAX = 32'hFFFF_FFFF;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_held_valid && !w_ready && !bus.flush &&
                     (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule
`default_nettype wire
